// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
// Build option: define PISO_PARITY_EN to append an even-parity bit to every frame.
package piso_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Terminal count of the bit counter: last frame index (FRAME_LEN-1).
  function automatic int frame_len(input int width, input bit parity);
    return width + int'(parity) - 1;
  endfunction

  // Counter width able to hold 0..FRAME_LEN-1.
  function automatic int cnt_w(input int width, input bit parity);
    return $clog2(width + int'(parity));
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial line of the serializer.
//   master : word source / line observer (drives din, load_valid)
//   slave  : the serializer (drives load_ready, dout, dout_valid, dout_last, busy)
interface piso_serializer_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             dout;
  logic             dout_valid;
  logic             dout_last;
  logic             busy;

  modport master (output din, load_valid,
                  input  load_ready, dout, dout_valid, dout_last, busy);
  modport slave  (input  din, load_valid,
                  output load_ready, dout, dout_valid, dout_last, busy);
endinterface

// File: rtl/piso_bit_counter.sv
// Frame bit index counter.
//   clk, rst_n : clock, async active-low reset
//   load       : restart at 0 (wins over en)
//   en         : advance by one; saturates at TERM
//   cnt        : current bit index
//   term       : cnt has reached TERM
module piso_bit_counter #(
  parameter int CNT_W = 2,
  parameter int TERM  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  assign term = (cnt == CNT_W'(TERM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (load)          cnt <= '0;
    else if (en && !term)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter. Takes a WIDTH-bit word on a valid/ready
// handshake and sends it one bit per clk on dout, first bit in the cycle after
// accept. load_ready is also high on the last bit so frames run back to back.
//   clk, rst_n : clock, async active-low reset
//   bus        : piso_serializer_if.slave (din/load_valid/load_ready in,
//                dout/dout_valid/dout_last/busy out)
// Parameters: WIDTH (>=2), LSB_FIRST (0: din[WIDTH-1] first, 1: din[0] first).
// Build option: PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  piso_serializer_if.slave   bus
);

  localparam int TERM  = frame_len(WIDTH, PARITY_EN);
  localparam int CNT_W = cnt_w(WIDTH, PARITY_EN);

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  shreg;
  logic              dout_r;
  logic [CNT_W-1:0]  cnt;
  logic              term;
  logic              last;
  logic              accept;
  logic              out_bit;
  logic              next_bit;

  assign last   = (state == SHIFT) && term;
  assign accept = bus.load_valid && bus.load_ready;

  assign bus.load_ready = (state == IDLE) || last;
  assign bus.dout       = dout_r;
  assign bus.dout_valid = (state == SHIFT);
  assign bus.busy       = (state == SHIFT);
  assign bus.dout_last  = last;

  piso_bit_counter #(.CNT_W(CNT_W), .TERM(TERM)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .en    (state == SHIFT),
    .cnt   (cnt),
    .term  (term)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)          state_nxt = SHIFT;
      SHIFT:   if (last && !accept) state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // shreg always holds the bits still to go, next one at the output end.
  assign out_bit = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];

`ifdef PISO_PARITY_EN
  logic par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      par <= 1'b0;
    else if (accept) par <= ^bus.din;
  end

  // After the final data bit the parity bit goes out instead of shreg.
  assign next_bit = (cnt == CNT_W'(WIDTH-1)) ? par : out_bit;
`else
  assign next_bit = out_bit;
`endif

  // The first bit is registered straight from din, so shreg keeps the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      dout_r <= 1'b0;
    end else if (accept) begin
      dout_r <= LSB_FIRST ? bus.din[0] : bus.din[WIDTH-1];
      shreg  <= LSB_FIRST ? (bus.din >> 1) : (bus.din << 1);
    end else if ((state == SHIFT) && !term) begin
      dout_r <= next_bit;
      shreg  <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
    end else begin
      dout_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share one
// stimulus; a queue-of-bits model predicts each line cycle by cycle.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic [3:0] din;

  piso_serializer_if #(.WIDTH(4)) if_m ();
  piso_serializer_if #(.WIDTH(4)) if_l ();

  assign if_m.din        = din;
  assign if_m.load_valid = load_valid;
  assign if_l.din        = din;
  assign if_l.load_valid = load_valid;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_m (.clk(clk), .rst_n(rst_n), .bus(if_m));
  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bits still to appear on each line, front = bit on the line this cycle.
  bit qm[$];
  bit ql[$];

  logic [15:0] obs_m, obs_l;
  int          nv_m, nv_l;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [3:0] d);
    for (int i = 3; i >= 0; i--) qm.push_back(d[i]);
    for (int i = 0; i < 4; i++)  ql.push_back(d[i]);
`ifdef PISO_PARITY_EN
    qm.push_back(^d);
    ql.push_back(^d);
`endif
  endtask

  // Entered and left at negedge: drive, check the cycle, advance the model.
  task automatic cycle(input logic v, input logic [3:0] d);
    logic rdy;
    load_valid = v;
    din        = d;
    #1;
    rdy = (qm.size() <= 1);
    chk("m_valid", if_m.dout_valid, qm.size() != 0);
    chk("m_busy",  if_m.busy,       qm.size() != 0);
    chk("m_dout",  if_m.dout,       (qm.size() != 0) ? qm[0] : 1'b0);
    chk("m_last",  if_m.dout_last,  qm.size() == 1);
    chk("m_ready", if_m.load_ready, rdy);
    chk("l_valid", if_l.dout_valid, ql.size() != 0);
    chk("l_dout",  if_l.dout,       (ql.size() != 0) ? ql[0] : 1'b0);
    chk("l_last",  if_l.dout_last,  ql.size() == 1);
    chk("l_ready", if_l.load_ready, rdy);
    if (if_m.dout_valid) begin obs_m = {obs_m[14:0], if_m.dout}; nv_m++; end
    if (if_l.dout_valid) begin obs_l = {obs_l[14:0], if_l.dout}; nv_l++; end
    @(posedge clk);
    if (qm.size() != 0) void'(qm.pop_front());
    if (ql.size() != 0) void'(ql.pop_front());
    if (v && rdy) push_frame(d);
    @(negedge clk);
  endtask

  task automatic clr_obs();
    obs_m = '0; obs_l = '0; nv_m = 0; nv_l = 0;
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    din        = 4'h0;
    clr_obs();
    #1;
    chk("rst_valid", {if_m.dout_valid, if_l.dout_valid}, 2'b00);
    chk("rst_dout",  {if_m.dout, if_l.dout},             2'b00);
    chk("rst_last",  {if_m.dout_last, if_l.dout_last},   2'b00);
    chk("rst_busy",  {if_m.busy, if_l.busy},             2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single frame 1011, then idle.
    clr_obs();
    cycle(1'b1, 4'b1011);
    repeat (FLEN + 2) cycle(1'b0, 4'h0);
`ifdef PISO_PARITY_EN
    chk("msb_1011", obs_m, 16'b10111);
    chk("lsb_1011", obs_l, 16'b11011);
`else
    chk("msb_1011", obs_m, 16'b1011);
    chk("lsb_1011", obs_l, 16'b1101);
`endif
    chk("nvalid_1011", nv_m, FLEN);

    // load_valid held: A then 5 back to back.
    clr_obs();
    cycle(1'b1, 4'hA);
    repeat (FLEN) cycle(1'b1, 4'h5);
    repeat (FLEN + 2) cycle(1'b0, 4'h0);
`ifdef PISO_PARITY_EN
    chk("b2b_bits", obs_m, 16'b1010001010);
`else
    chk("b2b_bits", obs_m, 16'b10100101);
`endif
    chk("b2b_nvalid", nv_m, 2 * FLEN);

    // Pulse while busy, not on last bit: ignored.
    cycle(1'b1, 4'hC);
    cycle(1'b0, 4'h0);
    cycle(1'b1, 4'h3);
    repeat (FLEN + 2) cycle(1'b0, 4'h0);

    // Reset after two bits of a frame.
    cycle(1'b1, 4'b0110);
    cycle(1'b0, 4'h0);
    cycle(1'b0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {if_m.dout_valid, if_l.dout_valid}, 2'b00);
    chk("midrst_dout",  {if_m.dout, if_l.dout},             2'b00);
    chk("midrst_busy",  {if_m.busy, if_l.busy},             2'b00);
    chk("midrst_last",  {if_m.dout_last, if_l.dout_last},   2'b00);
    qm.delete();
    ql.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clr_obs();
    cycle(1'b1, 4'b1001);
    repeat (FLEN + 1) cycle(1'b0, 4'h0);
    chk("fresh_nvalid", nv_m, FLEN);

    // Random traffic.
    repeat (400) cycle($urandom_range(0, 3) != 0, 4'($urandom));
    repeat (FLEN + 2) cycle(1'b0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
